imm_reverse_lut: RTL and testbench

//  Reverse immediate lookup: given an 8-bit constant, returns the 5-bit index whose Imm table entry equals it.

---
 rtl/imm_pkg.sv | 27 ++
 rtl/imm_reverse_lut_if.sv | 24 ++
 rtl/imm_table_rom.sv | 13 +
 rtl/imm_reverse_lut.sv | 116 +++++++++++
 tb/tb_imm_reverse_lut.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared types, table contents and FSM states for the immediate LUT.
// Used by imm_table_rom, imm_reverse_lut and the handshake interface.
package imm_pkg;
   localparam int IDX_W       = 5;
   localparam int VAL_W       = 8;
   localparam int IMM_ENTRIES = 24;

   typedef logic [IDX_W-1:0] imm_idx_t;
   typedef logic [VAL_W-1:0] imm_val_t;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      DONE
   } imm_state_t;

   localparam imm_val_t IMM_TABLE [IMM_ENTRIES] = '{
      8'd0,   8'd1,   8'd2,   8'd3,
      8'd4,   8'd5,   8'd6,   8'd14,
      8'd16,  8'd30,  8'd31,  8'd32,
      8'd33,  8'd60,  8'd91,  8'd109,
      8'd142, 8'd170, 8'd204, 8'd224,
      8'd225, 8'd240, 8'd247, 8'd254
   };

   localparam imm_idx_t IMM_LAST = imm_idx_t'(IMM_ENTRIES - 1);
endpackage

// File: rtl/imm_reverse_lut_if.sv
// Request/response handshake bundle for the reverse immediate lookup.
// master: requester (req_valid/req_value/resp_ready); slave: the LUT.
interface imm_reverse_lut_if
   import imm_pkg::*;
   ();
   logic     req_valid;
   imm_val_t req_value;
   logic     req_ready;
   logic     resp_valid;
   logic     resp_ready;
   imm_idx_t resp_index;
   logic     resp_hit;
   logic     busy;

   modport master (
      output req_valid, req_value, resp_ready,
      input  req_ready, resp_valid, resp_index, resp_hit, busy
   );

   modport slave (
      input  req_valid, req_value, resp_ready,
      output req_ready, resp_valid, resp_index, resp_hit, busy
   );
endinterface

// File: rtl/imm_table_rom.sv
// Combinational immediate table: idx_i -> val_o, out-of-range gives 0.
// Ports: idx_i (table index), val_o (table value). Shared with forward LUT.
module imm_table_rom
   import imm_pkg::*;
(
   input  imm_idx_t idx_i,
   output imm_val_t val_o
);
   always_comb begin
      val_o = '0;
      if (idx_i <= IMM_LAST) val_o = IMM_TABLE[idx_i];
   end
endmodule

// File: rtl/imm_reverse_lut.sv
// Reverse immediate lookup: scans the table one entry per cycle for a value.
// Ports: Clk, Reset_n (async low), bus (slave handshake: req_*, resp_*, busy).
// Optional macro IMM_REV_CACHE_EN adds a one-entry last-result cache.
module imm_reverse_lut
   import imm_pkg::*;
#(
   parameter int ENTRIES = IMM_ENTRIES
) (
   input logic               Clk,
   input logic               Reset_n,
   imm_reverse_lut_if.slave  bus
);
   localparam imm_idx_t LAST = imm_idx_t'(ENTRIES - 1);

   imm_state_t state_q;
   imm_idx_t   cnt_q;
   imm_val_t   val_q;
   imm_idx_t   idx_q;
   logic       hit_q;

   imm_val_t   rom_d;
   logic       accept_d;
   logic       match_d;
   logic       done_d;
   imm_idx_t   res_idx_d;
   logic       cache_match_d;
   imm_idx_t   cache_idx_d;
   logic       cache_hit_d;

   imm_table_rom u_rom (
      .idx_i (cnt_q),
      .val_o (rom_d)
   );

   assign accept_d  = bus.req_valid && (state_q == IDLE);
   assign match_d   = (rom_d == val_q);
   assign done_d    = (state_q == SEARCH) && (match_d || cnt_q == LAST);
   assign res_idx_d = match_d ? cnt_q : '0;

`ifdef IMM_REV_CACHE_EN
   logic     cache_vld_q;
   imm_val_t cache_val_q;
   imm_idx_t cache_idx_q;
   logic     cache_hit_q;

   assign cache_match_d = cache_vld_q && (bus.req_value == cache_val_q);
   assign cache_idx_d   = cache_idx_q;
   assign cache_hit_d   = cache_hit_q;

   // Only scan results are written; a cache hit re-enters DONE with
   // the same contents, so rewriting it would change nothing.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cache_vld_q <= 1'b0;
         cache_val_q <= '0;
         cache_idx_q <= '0;
         cache_hit_q <= 1'b0;
      end else if (done_d) begin
         cache_vld_q <= 1'b1;
         cache_val_q <= val_q;
         cache_idx_q <= res_idx_d;
         cache_hit_q <= match_d;
      end
   end
`else
   assign cache_match_d = 1'b0;
   assign cache_idx_d   = '0;
   assign cache_hit_d   = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         val_q   <= '0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept_d) begin
                  val_q <= bus.req_value;
                  cnt_q <= '0;
                  if (cache_match_d) begin
                     state_q <= DONE;
                     idx_q   <= cache_idx_d;
                     hit_q   <= cache_hit_d;
                  end else begin
                     state_q <= SEARCH;
                  end
               end
            end
            SEARCH: begin
               if (done_d) begin
                  state_q <= DONE;
                  idx_q   <= res_idx_d;
                  hit_q   <= match_d;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (bus.resp_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs decode flops only; there is no input-to-ready path.
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.busy       = (state_q == SEARCH);
   assign bus.resp_valid = (state_q == DONE);
   assign bus.resp_index = idx_q;
   assign bus.resp_hit   = hit_q;
endmodule

// File: tb/tb_imm_reverse_lut.sv
// Directed bench for imm_reverse_lut: latency, index/hit, stall, reset abort.
// Build with +define+IMM_REV_CACHE_EN to check the cached-repeat path.
module tb_imm_reverse_lut;
   import imm_pkg::*;

`ifdef IMM_REV_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   imm_reverse_lut_if bus ();

   imm_reverse_lut dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one request; return edges from accept to resp_valid.
   task automatic do_req(input string tag, input imm_val_t v,
                         output int lat);
      @(negedge Clk);
      chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_value = v;
      @(posedge Clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_value = ~v;
      lat = 0;
      while (!bus.resp_valid && lat < 40) begin
         @(posedge Clk);
         #1;
         lat++;
      end
   endtask

   task automatic take_resp(input string tag);
      @(negedge Clk);
      bus.resp_ready = 1'b1;
      @(posedge Clk);
      #1;
      bus.resp_ready = 1'b0;
      chk({tag, "_idle"}, {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);
   endtask

   task automatic run(input string tag, input imm_val_t v,
                      input int elat, input imm_idx_t eidx, input logic ehit);
      int lat;
      do_req(tag, v, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      chk({tag, "_res"}, {26'd0, bus.resp_hit, bus.resp_index},
          {26'd0, ehit, eidx});
      take_resp(tag);
   endtask

   initial begin
      int lat;
      int seen;
      bus.req_valid  = 1'b0;
      bus.req_value  = '0;
      bus.resp_ready = 1'b0;
      #1;
      chk("rst_out", {27'd0, bus.req_ready, bus.resp_valid, bus.busy,
                      bus.resp_hit, 1'b0},
          {27'd0, 5'b10000});
      chk("rst_idx", 32'(bus.resp_index), 32'd0);
      #12;
      Reset_n = 1'b1;
      seen = 0;
      repeat (3) begin
         @(posedge Clk);
         #1;
         if (bus.resp_valid) seen++;
      end
      chk("idle3", 32'(seen), 32'd0);

      run("v00", 8'h00, 1, 5'd0, 1'b1);
      run("vFE", 8'hFE, 24, 5'd23, 1'b1);
      run("v8E", 8'h8E, 17, 5'd16, 1'b1);
      run("v07", 8'h07, 24, 5'd0, 1'b0);

      // Stalled response: 33 lives at index 12.
      do_req("stl", 8'd33, lat);
      chk("stl_lat", 32'(lat), 32'd13);
      repeat (5) begin
         @(posedge Clk);
         #1;
         chk("stl_hold", {25'd0, bus.resp_valid, bus.req_ready,
                          bus.resp_hit, bus.resp_index},
             {25'd0, 1'b1, 1'b0, 1'b1, 5'd12});
      end
      take_resp("stl");
      run("v05", 8'd5, 6, 5'd5, 1'b1);

      // Abort a scan for 240 (index 21) once the counter reaches 10.
      do_req("abt", 8'd240, lat);
      chk("abt_early", 32'(lat), 32'd22);
      take_resp("abt0");
      do_req("abt1", 8'd240, lat);
      chk("abt1_lat", 32'(lat), (CACHE ? 32'd0 : 32'd22));
      take_resp("abt1");
      run("v91", 8'd91, 15, 5'd14, 1'b1);
      @(negedge Clk);
      bus.req_valid = 1'b1;
      bus.req_value = 8'd240;
      @(posedge Clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (10) @(posedge Clk);
      #1;
      chk("abt_busy", 32'(bus.busy), 32'd1);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("abt_out", {27'd0, bus.req_ready, bus.resp_valid, bus.busy,
                      bus.resp_hit, 1'b0},
          {27'd0, 5'b10000});
      chk("abt_idx", 32'(bus.resp_index), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge Clk);
         #1;
         if (bus.resp_valid) seen++;
      end
      chk("abt_quiet", 32'(seen), 32'd0);

      // After reset the cache is empty: first 142 always scans.
      run("c8E0", 8'd142, 17, 5'd16, 1'b1);
      run("c8E1", 8'd142, CACHE ? 0 : 17, 5'd16, 1'b1);
      run("c070", 8'h07, 24, 5'd0, 1'b0);
      run("c071", 8'h07, CACHE ? 0 : 24, 5'd0, 1'b0);
      run("vFF", 8'hFF, 24, 5'd0, 1'b0);
      run("vE1", 8'd225, 21, 5'd20, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
